// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage
// Brief    : Execute stage between ID and MEM. It computes ALU, address and
//            link results, and resolves branches/jumps. It has an optional
//            1-bit-per-cycle shifter and a synchronous flush.
// Revision : 1.0 - initial release
// ============================================================================
module ex_stage #(
  parameter int BITSIZE      = 32,
  parameter int SERIAL_SHIFT = 0
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic               flush_i,
  input  logic               ID_EX_give_i,
  output logic               EX_ID_get_o,
  input  logic [31:0]        ID_EX_instruction_i,
  input  logic [BITSIZE-1:0] ID_EX_pc_i,
  input  logic [BITSIZE-1:0] ID_EX_rs1_i,
  input  logic [BITSIZE-1:0] ID_EX_rs2_i,
  input  logic [BITSIZE-1:0] ID_EX_imm_i,
  input  logic               MEM_EX_get_i,
  output logic               EX_MEM_give_o,
  output logic [31:0]        EX_MEM_instruction_o,
  output logic [BITSIZE-1:0] EX_MEM_d_o,
  output logic [BITSIZE-1:0] EX_MEM_rs2_o,
  output logic               EX_MEM_branch_o,
  output logic [BITSIZE-1:0] EX_MEM_target_o
);

  localparam int c_SW = $clog2(BITSIZE);

  localparam logic [1:0] c_EMPTY = 2'd0;
  localparam logic [1:0] c_FULL  = 2'd1;
  localparam logic [1:0] c_SHIFT = 2'd2;

  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;

  localparam logic [BITSIZE-1:0] c_FOUR     = BITSIZE'(4);
  localparam logic [BITSIZE-1:0] c_LSB_MASK = ~BITSIZE'(1);
  localparam logic [c_SW-1:0]    c_CNT_ONE  = c_SW'(1);

  logic [1:0]         r_state;
  logic [c_SW-1:0]    r_cnt;
  logic [31:0]        r_instr;
  logic [BITSIZE-1:0] r_d;
  logic [BITSIZE-1:0] r_rs2;
  logic               r_branch;
  logic [BITSIZE-1:0] r_target;

  logic [6:0]         w_opcode;
  logic [2:0]         w_f3;
  logic               w_alt;
  logic [BITSIZE-1:0] w_b;
  logic [c_SW-1:0]    w_shamt;
  logic [BITSIZE-1:0] w_sra;
  logic [BITSIZE-1:0] w_d;
  logic               w_branch;
  logic [BITSIZE-1:0] w_target;
  logic               w_is_shift;
  logic               w_serial_go;
  logic               w_accept;
  logic [BITSIZE-1:0] w_step;

  assign w_opcode = ID_EX_instruction_i[6:0];
  assign w_f3     = ID_EX_instruction_i[14:12];
  assign w_alt    = ID_EX_instruction_i[30];
  assign w_b      = (w_opcode == c_OPC_OP) ? ID_EX_rs2_i : ID_EX_imm_i;
  assign w_shamt  = w_b[c_SW-1:0];
  assign w_sra    = $signed(ID_EX_rs1_i) >>> w_shamt;

  assign w_is_shift  = ((w_opcode == c_OPC_OPIMM) || (w_opcode == c_OPC_OP)) &&
                       ((w_f3 == 3'b001) || (w_f3 == 3'b101));
  assign w_serial_go = (SERIAL_SHIFT != 0) && w_is_shift && (w_shamt != '0);

  assign EX_ID_get_o = !reset_i && !flush_i &&
                       ((r_state == c_EMPTY) || ((r_state == c_FULL) && MEM_EX_get_i));
  assign w_accept    = ID_EX_give_i && EX_ID_get_o;

  // The shifting operand lives in r_d; direction and fill come from the held instruction.
  assign w_step = (r_instr[14:12] == 3'b001) ? {r_d[BITSIZE-2:0], 1'b0}
                                             : {r_instr[30] & r_d[BITSIZE-1], r_d[BITSIZE-1:1]};

  always_comb begin
    w_d      = '0;
    w_branch = 1'b0;
    w_target = '0;
    case (w_opcode)
      c_OPC_LUI:   w_d = ID_EX_imm_i;
      c_OPC_AUIPC: w_d = ID_EX_pc_i + ID_EX_imm_i;
      c_OPC_OPIMM, c_OPC_OP: begin
        case (w_f3)
          3'b000: begin
            if ((w_opcode == c_OPC_OP) && w_alt) w_d = ID_EX_rs1_i - w_b;
            else                                 w_d = ID_EX_rs1_i + w_b;
          end
          3'b001: w_d = ID_EX_rs1_i << w_shamt;
          3'b010: w_d = {{(BITSIZE-1){1'b0}}, ($signed(ID_EX_rs1_i) < $signed(w_b))};
          3'b011: w_d = {{(BITSIZE-1){1'b0}}, (ID_EX_rs1_i < w_b)};
          3'b100: w_d = ID_EX_rs1_i ^ w_b;
          3'b101: begin
            if (w_alt) w_d = w_sra;
            else       w_d = ID_EX_rs1_i >> w_shamt;
          end
          3'b110: w_d = ID_EX_rs1_i | w_b;
          default: w_d = ID_EX_rs1_i & w_b;
        endcase
      end
      c_OPC_LOAD, c_OPC_STORE: w_d = ID_EX_rs1_i + ID_EX_imm_i;
      c_OPC_BRANCH: begin
        case (w_f3)
          3'b000:  w_branch = (ID_EX_rs1_i == ID_EX_rs2_i);
          3'b001:  w_branch = (ID_EX_rs1_i != ID_EX_rs2_i);
          3'b100:  w_branch = ($signed(ID_EX_rs1_i) <  $signed(ID_EX_rs2_i));
          3'b101:  w_branch = ($signed(ID_EX_rs1_i) >= $signed(ID_EX_rs2_i));
          3'b110:  w_branch = (ID_EX_rs1_i <  ID_EX_rs2_i);
          3'b111:  w_branch = (ID_EX_rs1_i >= ID_EX_rs2_i);
          default: w_branch = 1'b0;
        endcase
        w_target = w_branch ? (ID_EX_pc_i + ID_EX_imm_i) : '0;
      end
      c_OPC_JAL: begin
        w_d      = ID_EX_pc_i + c_FOUR;
        w_branch = 1'b1;
        w_target = ID_EX_pc_i + ID_EX_imm_i;
      end
      c_OPC_JALR: begin
        w_d      = ID_EX_pc_i + c_FOUR;
        w_branch = 1'b1;
        w_target = (ID_EX_rs1_i + ID_EX_imm_i) & c_LSB_MASK;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_state  <= c_EMPTY;
      r_cnt    <= '0;
      r_instr  <= '0;
      r_d      <= '0;
      r_rs2    <= '0;
      r_branch <= 1'b0;
      r_target <= '0;
    end else if (flush_i) begin
      r_state <= c_EMPTY;
    end else if (w_accept) begin
      r_instr <= ID_EX_instruction_i;
      r_rs2   <= ID_EX_rs2_i;
      if (w_serial_go) begin
        r_state  <= c_SHIFT;
        r_d      <= ID_EX_rs1_i;
        r_cnt    <= w_shamt;
        r_branch <= 1'b0;
        r_target <= '0;
      end else begin
        r_state  <= c_FULL;
        r_d      <= w_d;
        r_branch <= w_branch;
        r_target <= w_target;
      end
    end else begin
      case (r_state)
        c_FULL: begin
          if (MEM_EX_get_i) r_state <= c_EMPTY;
        end
        c_SHIFT: begin
          r_d   <= w_step;
          r_cnt <= r_cnt - c_CNT_ONE;
          if (r_cnt == c_CNT_ONE) r_state <= c_FULL;
        end
        c_EMPTY: ;
        default: r_state <= c_EMPTY;
      endcase
    end
  end

  assign EX_MEM_give_o        = (r_state == c_FULL);
  assign EX_MEM_instruction_o = r_instr;
  assign EX_MEM_d_o           = r_d;
  assign EX_MEM_rs2_o         = r_rs2;
  assign EX_MEM_branch_o      = r_branch;
  assign EX_MEM_target_o      = r_target;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_stage
// Brief    : Self-checking bench for ex_stage (barrel and serial shifter builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_stage;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] d;
    logic        br;
    logic [31:0] tgt;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_i, flush_i, give_i, mem_get;
  logic [31:0] instr_i, pc_i, rs1_i, rs2_i, imm_i;
  logic        get_o, give_o, br_o;
  logic [31:0] instr_o, d_o, rs2_o, tgt_o;

  logic        s_flush, s_give, s_get;
  logic        s_get_o, s_give_o, s_br_o;
  logic [31:0] s_instr_o, s_d_o, s_rs2_o, s_tgt_o;

  int total = 0;
  int bad   = 0;
  vec_t sb[$];
  vec_t cur;
  vec_t tbl[25];

  always #5 clk = ~clk;

  ex_stage #(.BITSIZE(32), .SERIAL_SHIFT(0)) dut (
    .clk(clk), .reset_i(reset_i), .flush_i(flush_i),
    .ID_EX_give_i(give_i), .EX_ID_get_o(get_o),
    .ID_EX_instruction_i(instr_i), .ID_EX_pc_i(pc_i),
    .ID_EX_rs1_i(rs1_i), .ID_EX_rs2_i(rs2_i), .ID_EX_imm_i(imm_i),
    .MEM_EX_get_i(mem_get), .EX_MEM_give_o(give_o),
    .EX_MEM_instruction_o(instr_o), .EX_MEM_d_o(d_o), .EX_MEM_rs2_o(rs2_o),
    .EX_MEM_branch_o(br_o), .EX_MEM_target_o(tgt_o)
  );

  ex_stage #(.BITSIZE(32), .SERIAL_SHIFT(1)) dut_s (
    .clk(clk), .reset_i(reset_i), .flush_i(s_flush),
    .ID_EX_give_i(s_give), .EX_ID_get_o(s_get_o),
    .ID_EX_instruction_i(instr_i), .ID_EX_pc_i(pc_i),
    .ID_EX_rs1_i(rs1_i), .ID_EX_rs2_i(rs2_i), .ID_EX_imm_i(imm_i),
    .MEM_EX_get_i(s_get), .EX_MEM_give_o(s_give_o),
    .EX_MEM_instruction_o(s_instr_o), .EX_MEM_d_o(s_d_o), .EX_MEM_rs2_o(s_rs2_o),
    .EX_MEM_branch_o(s_br_o), .EX_MEM_target_o(s_tgt_o)
  );

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input logic alt);
    return {1'b0, alt, 15'd0, f3, 5'd0, op};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    instr_i = v.instr; pc_i = v.pc; rs1_i = v.rs1; rs2_i = v.rs2; imm_i = v.imm;
    cur = v;
  endtask

  // One cycle from a negedge: retire/record handshakes, then advance to the next negedge.
  task automatic cyc();
    vec_t e;
    #1;
    if (give_o && mem_get) begin
      if (sb.size() == 0) chk("sb_unexpected_out", d_o, 32'hxxxx_xxxx);
      else begin
        e = sb.pop_front();
        chk("sb_d", d_o, e.d);
        chk("sb_branch", {31'd0, br_o}, {31'd0, e.br});
        chk("sb_target", tgt_o, e.tgt);
        chk("sb_rs2", rs2_o, e.rs2);
        chk("sb_instr", instr_o, e.instr);
      end
    end
    if (give_i && get_o) sb.push_back(cur);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    give_i = 1'b0;
    mem_get = 1'b1;
    for (int i = 0; i < 8 && sb.size() != 0; i++) cyc();
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    #1 chk("drained_give", {31'd0, give_o}, 32'd0);
    @(negedge clk);
  endtask

  // Serial unit: accept one shift, expect give exactly lat cycles later with d = expd.
  task automatic serial_run(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] im,
                            input int lat, input logic [31:0] expd);
    instr_i = ins; rs1_i = a; imm_i = im; rs2_i = 32'h0; s_give = 1'b1; s_get = 1'b1;
    #1 chk("ser_accept_get", {31'd0, s_get_o}, 32'd1);
    @(posedge clk); @(negedge clk);
    s_give = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      #1;
      if (k < lat) begin
        chk("ser_busy_give", {31'd0, s_give_o}, 32'd0);
        chk("ser_busy_get", {31'd0, s_get_o}, 32'd0);
        @(posedge clk); @(negedge clk);
      end else begin
        chk("ser_done_give", {31'd0, s_give_o}, 32'd1);
        chk("ser_done_d", s_d_o, expd);
      end
    end
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    tbl[0]  = '{mk(7'h13,3'd0,1'b0), 32'h0,   32'd5,        32'd0,        32'hFFFFFFFF, 32'd4,        1'b0, 32'h0};
    tbl[1]  = '{mk(7'h33,3'd0,1'b0), 32'h0,   32'd10,       32'd3,        32'h0,        32'd13,       1'b0, 32'h0};
    tbl[2]  = '{mk(7'h33,3'd0,1'b1), 32'h0,   32'd3,        32'd10,       32'h0,        32'hFFFFFFF9, 1'b0, 32'h0};
    tbl[3]  = '{mk(7'h33,3'd1,1'b0), 32'h0,   32'd1,        32'd31,       32'h0,        32'h80000000, 1'b0, 32'h0};
    tbl[4]  = '{mk(7'h33,3'd2,1'b0), 32'h0,   32'hFFFFFFFF, 32'd1,        32'h0,        32'd1,        1'b0, 32'h0};
    tbl[5]  = '{mk(7'h33,3'd3,1'b0), 32'h0,   32'hFFFFFFFF, 32'd1,        32'h0,        32'd0,        1'b0, 32'h0};
    tbl[6]  = '{mk(7'h13,3'd4,1'b0), 32'h0,   32'hF0F0,     32'd0,        32'hFF,       32'hF00F,     1'b0, 32'h0};
    tbl[7]  = '{mk(7'h33,3'd5,1'b0), 32'h0,   32'h80000000, 32'd4,        32'h0,        32'h08000000, 1'b0, 32'h0};
    tbl[8]  = '{mk(7'h13,3'd5,1'b1), 32'h0,   32'h80000000, 32'd0,        32'h404,      32'hF8000000, 1'b0, 32'h0};
    tbl[9]  = '{mk(7'h13,3'd6,1'b0), 32'h0,   32'h10,       32'd0,        32'h1,        32'h11,       1'b0, 32'h0};
    tbl[10] = '{mk(7'h33,3'd7,1'b0), 32'h0,   32'hFF,       32'h0F,       32'h0,        32'h0F,       1'b0, 32'h0};
    tbl[11] = '{mk(7'h37,3'd0,1'b0), 32'h0,   32'h55,       32'd0,        32'h12345000, 32'h12345000, 1'b0, 32'h0};
    tbl[12] = '{mk(7'h17,3'd0,1'b0), 32'h1000,32'h0,        32'd0,        32'h20,       32'h1020,     1'b0, 32'h0};
    tbl[13] = '{mk(7'h03,3'd2,1'b0), 32'h0,   32'h100,      32'd0,        32'h8,        32'h108,      1'b0, 32'h0};
    tbl[14] = '{mk(7'h23,3'd2,1'b0), 32'h0,   32'h200,      32'hDEADBEEF, 32'hFFFFFFFC, 32'h1FC,      1'b0, 32'h0};
    tbl[15] = '{mk(7'h63,3'd0,1'b0), 32'h40,  32'd7,        32'd7,        32'h10,       32'h0,        1'b1, 32'h50};
    tbl[16] = '{mk(7'h63,3'd1,1'b0), 32'h40,  32'd7,        32'd7,        32'h10,       32'h0,        1'b0, 32'h0};
    tbl[17] = '{mk(7'h63,3'd4,1'b0), 32'h40,  32'hFFFFFFFF, 32'd1,        32'h10,       32'h0,        1'b1, 32'h50};
    tbl[18] = '{mk(7'h63,3'd6,1'b0), 32'h40,  32'hFFFFFFFF, 32'd1,        32'h10,       32'h0,        1'b0, 32'h0};
    tbl[19] = '{mk(7'h63,3'd5,1'b0), 32'h40,  32'hFFFFFFFF, 32'd1,        32'h10,       32'h0,        1'b0, 32'h0};
    tbl[20] = '{mk(7'h63,3'd7,1'b0), 32'h40,  32'hFFFFFFFF, 32'd1,        32'h10,       32'h0,        1'b1, 32'h50};
    tbl[21] = '{mk(7'h63,3'd2,1'b0), 32'h40,  32'd1,        32'd2,        32'h10,       32'h0,        1'b0, 32'h0};
    tbl[22] = '{mk(7'h6F,3'd0,1'b0), 32'h100, 32'h0,        32'd0,        32'hFFFFFFF0, 32'h104,      1'b1, 32'hF0};
    tbl[23] = '{mk(7'h67,3'd0,1'b0), 32'h300, 32'h203,      32'd0,        32'h4,        32'h304,      1'b1, 32'h206};
    tbl[24] = '{mk(7'h0F,3'd0,1'b0), 32'h0,   32'd5,        32'd0,        32'd5,        32'h0,        1'b0, 32'h0};

    reset_i = 1'b1; flush_i = 1'b0; give_i = 1'b0; mem_get = 1'b1;
    s_flush = 1'b0; s_give = 1'b0; s_get = 1'b1;
    instr_i = '0; pc_i = '0; rs1_i = '0; rs2_i = '0; imm_i = '0;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_give", {31'd0, give_o}, 32'd0);
    chk("rst_get", {31'd0, get_o}, 32'd0);
    chk("rst_d", d_o, 32'd0);
    @(negedge clk);
    reset_i = 1'b0;
    #1 chk("post_rst_get", {31'd0, get_o}, 32'd1);

    // Back-to-back stream: get must stay high, give high from the second cycle on.
    give_i = 1'b1;
    for (int i = 0; i < 25; i++) begin
      apply(tbl[i]);
      #1 chk("stream_get", {31'd0, get_o}, 32'd1);
      if (i > 0) chk("stream_give", {31'd0, give_o}, 32'd1);
      cyc();
    end
    drain();

    // Backpressure on a load; the queued ADDI enters on the edge MEM takes the load.
    give_i = 1'b1;
    apply(tbl[13]);
    cyc();
    mem_get = 1'b0;
    apply(tbl[0]);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_give", {31'd0, give_o}, 32'd1);
      chk("bp_d", d_o, 32'h108);
      chk("bp_get", {31'd0, get_o}, 32'd0);
      @(posedge clk); @(negedge clk);
    end
    mem_get = 1'b1;
    #1 chk("bp_release_get", {31'd0, get_o}, 32'd1);
    cyc();
    drain();

    // Flush while FULL.
    give_i = 1'b1; mem_get = 1'b0;
    apply(tbl[1]);
    cyc();
    give_i = 1'b0; flush_i = 1'b1;
    #1 chk("flush_get", {31'd0, get_o}, 32'd0);
    @(posedge clk); @(negedge clk);
    flush_i = 1'b0;
    #1 chk("flush_give", {31'd0, give_o}, 32'd0);
    chk("flush_after_get", {31'd0, get_o}, 32'd1);
    sb.delete();
    @(negedge clk);

    // Asynchronous reset while FULL.
    give_i = 1'b1;
    apply(tbl[12]);
    cyc();
    give_i = 1'b0;
    #2 reset_i = 1'b1;
    #1;
    chk("async_rst_give", {31'd0, give_o}, 32'd0);
    chk("async_rst_d", d_o, 32'd0);
    sb.delete();
    @(negedge clk);
    reset_i = 1'b0;
    mem_get = 1'b1;
    @(negedge clk);

    // Serial shifter: latency shamt+1, shamt 0 takes one cycle.
    serial_run(mk(7'h13,3'd5,1'b1), 32'h80000000, 32'h405, 6, 32'hFC000000);
    serial_run(mk(7'h13,3'd1,1'b0), 32'h1, 32'h3, 4, 32'h8);
    serial_run(mk(7'h13,3'd1,1'b0), 32'h1234, 32'h0, 1, 32'h1234);
    serial_run(mk(7'h33,3'd5,1'b0), 32'hF0000000, 32'h0, 1, 32'hF0000000);

    // Flush during the second shift cycle aborts the instruction.
    instr_i = mk(7'h13,3'd5,1'b0); rs1_i = 32'hFFFFFFFF; imm_i = 32'h8; s_give = 1'b1;
    @(posedge clk); @(negedge clk);
    s_give = 1'b0;
    @(posedge clk); @(negedge clk);
    s_flush = 1'b1;
    #1 chk("ser_flush_get", {31'd0, s_get_o}, 32'd0);
    @(posedge clk); @(negedge clk);
    s_flush = 1'b0;
    #1 chk("ser_flush_after_get", {31'd0, s_get_o}, 32'd1);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
        #1 if (s_give_o) seen = 1'b1;
        @(posedge clk); @(negedge clk);
      end
      chk("ser_flush_no_give", {31'd0, seen}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
